// File: rtl/sd_pkg.sv
// Shared types and constants for the 1011 detector front end and its benches.
package sd_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } sd_state_e;

    localparam int unsigned SD_WORD_W = 8;

    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sd_serializer.sv
// Double-buffered parallel-to-serial converter: one word shifting on PO, one word waiting in hold.
module sd_serializer
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH      = SD_WORD_W,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             PO,
    output logic             po_valid,
    output logic             po_last,
    output logic             busy
);

    localparam int unsigned    CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sd_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             xfer;
    logic             last_bit;
    logic             head_bit;
    logic [WIDTH-1:0] shift_adv;

    assign in_ready = reset & ~hold_full_q;
    assign xfer     = in_valid & in_ready;
    assign last_bit = (state_q == StShift) && (cnt_q == CntLast);
    assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    // Consumed bit falls off the sending end; the vacated end fills with zero.
    assign shift_adv = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!last_bit) begin
                    shift_d = shift_adv;
                    cnt_d   = cnt_q + CntW'(1);
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // in_ready is low here, so no incoming word can collide with this move.
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (xfer) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        PO       = (state_q == StShift) ? head_bit : IDLE_LEVEL;
        po_valid = (state_q == StShift);
        po_last  = last_bit;
        busy     = (state_q == StShift) | hold_full_q;
    end

endmodule

// File: tb/tb_sd_serializer.sv
// Bench: MSB-first and LSB-first serializers driven together, checked against a word-FIFO model.
module tb_sd_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;

    logic [1:0] in_ready_w, po_w, po_valid_w, po_last_w, busy_w;

    always #5 clk = ~clk;

    sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_w[0]),
        .PO       (po_w[0]),
        .po_valid (po_valid_w[0]),
        .po_last  (po_last_w[0]),
        .busy     (busy_w[0])
    );

    sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready_w[1]),
        .PO       (po_w[1]),
        .po_valid (po_valid_w[1]),
        .po_last  (po_last_w[1]),
        .busy     (busy_w[1])
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model per instance: FIFO of up to two words; word 0 is the one on the wire, idx its bit position.
    logic [W-1:0] mw   [2][2];
    int           msz  [2];
    int           midx [2];
    logic         last_xfer;
    int           pv_cnt, pl_cnt;

    function automatic logic model_bit(input int m);
        if (msz[m] == 0) return 1'b0;
        return (m == 0) ? mw[m][0][W-1-midx[m]] : mw[m][0][midx[m]];
    endfunction

    task automatic step(input logic rst, input logic vld, input logic [W-1:0] d);
        logic xf [2];
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        in_data  = d;
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("po%0d", m),       32'(po_w[m]),       32'(model_bit(m)));
            check_eq($sformatf("po_valid%0d", m), 32'(po_valid_w[m]), 32'(msz[m] > 0));
            check_eq($sformatf("po_last%0d", m),  32'(po_last_w[m]),
                     32'(msz[m] > 0 && midx[m] == W - 1));
            check_eq($sformatf("busy%0d", m),     32'(busy_w[m]),     32'(msz[m] > 0));
            check_eq($sformatf("in_ready%0d", m), 32'(in_ready_w[m]), 32'(rst && msz[m] < 2));
            xf[m] = vld && rst && (msz[m] < 2);
        end
        pv_cnt += int'(po_valid_w[0]);
        pl_cnt += int'(po_last_w[0]);
        last_xfer = xf[0];
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                msz[m]  = 0;
                midx[m] = 0;
            end else begin
                if (msz[m] > 0) begin
                    midx[m]++;
                    if (midx[m] == W) begin
                        mw[m][0] = mw[m][1];
                        msz[m]--;
                        midx[m] = 0;
                    end
                end
                if (xf[m]) begin
                    mw[m][msz[m]] = d;
                    msz[m]++;
                end
            end
        end
    endtask

    // Holds the word stable until it is taken; an expired bound counts as a miscompare.
    task automatic send_word(input logic [W-1:0] d);
        int tries = 0;
        last_xfer = 1'b0;
        while (!last_xfer && tries < 40) begin
            step(1'b1, 1'b1, d);
            tries++;
        end
        if (!last_xfer) check_eq("send_timeout", 32'(tries), 32'(0));
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            msz[m]  = 0;
            midx[m] = 0;
        end
        pv_cnt = 0;
        pl_cnt = 0;

        // Reset held with a word offered: nothing may be accepted.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hA5);
        step(1'b1, 1'b0, '0);

        // Single word.
        send_word(8'hB0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);

        // Back-to-back with backpressure on the third word.
        pv_cnt = 0;
        pl_cnt = 0;
        send_word(8'hB0);
        send_word(8'hFF);
        send_word(8'h0D);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 8'h00);
        check_eq("b2b_valid_cycles", 32'(pv_cnt), 32'(24));
        check_eq("b2b_last_cycles",  32'(pl_cnt), 32'(3));

        // Reset after three bits, then a clean word.
        send_word(8'hB0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        send_word(8'h0F);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                 W'($urandom));
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
